// File: rtl/button_mmio.sv
// button_mmio
//   Debounced push-button peripheral that sits on the processor's data-memory
//   bus. It exposes the live debounced levels, sticky press-event flags that
//   are cleared by writing 1, and a 16-bit running press counter.
//
//   Register window (16 bytes at BASE_ADR, word offset adr[3:2]):
//     0 STATUS  RO   {zeros, btn_level}
//     1 EVENTS  W1C  {zeros, events}
//     2 COUNT   RO   {16'b0, presses}
//     3 reserved, reads 0
//
//   Ports:
//     clk, reset     system clock, synchronous active-high reset
//     btn            raw asynchronous active-high button pins
//     adr, we, wdata processor data address, store strobe, store data
//     hit            combinational window decode
//     rdata          combinational read data, 0 when hit is low
//     btn_level      registered debounced levels
//     pending        registered OR of all event flags
module button_mmio #(
    parameter int          NBTN            = 3,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] BASE_ADR        = 32'h0000_2000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn,
    input  logic [31:0]     adr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic            hit,
    output logic [31:0]     rdata,
    output logic [NBTN-1:0] btn_level,
    output logic            pending
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  s1;
    logic [NBTN-1:0]  s2;
    logic [CNT_W-1:0] cnt     [NBTN];
    logic [CNT_W-1:0] cnt_nxt [NBTN];
    logic [NBTN-1:0]  level_nxt;
    logic [NBTN-1:0]  rise;
    logic [NBTN-1:0]  clr;
    logic [NBTN-1:0]  events;
    logic [NBTN-1:0]  events_nxt;
    logic [15:0]      presses;
    logic [1:0]       word;

    // Number of set bits, sized for direct addition to the press counter.
    function automatic logic [15:0] popcount(input logic [NBTN-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < NBTN; i++) begin
            n = n + 16'(v[i]);
        end
        return n;
    endfunction

    assign word = adr[3:2];
    assign hit  = (adr[31:4] == BASE_ADR[31:4]);

    // Debounce: the counter only advances while the synchronized input
    // disagrees with the current level, so any return to the level restarts it.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            level_nxt[i] = btn_level[i];
            cnt_nxt[i]   = '0;
            if (s2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = level_nxt & ~btn_level;
    assign clr  = (hit && we && (word == 2'd1)) ? wdata[NBTN-1:0] : '0;

    // A rising level on the same edge as a W1C clear keeps the flag set.
    assign events_nxt = (events & ~clr) | rise;

    // Synchronizer, debounce and register state
    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            btn_level <= '0;
            events    <= '0;
            presses   <= '0;
            pending   <= 1'b0;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= btn;
            s2        <= s1;
            btn_level <= level_nxt;
            events    <= events_nxt;
            presses   <= presses + popcount(rise);
            pending   <= |events_nxt;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (word)
                2'd0:    rdata = 32'(btn_level);
                2'd1:    rdata = 32'(events);
                2'd2:    rdata = {16'b0, presses};
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_button_mmio.sv
module tb_button_mmio;

    logic        clk;
    logic        reset;
    logic [2:0]  btn;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic [2:0]  btn_level;
    logic        pending;

    int n_tests;
    int n_fail;

    button_mmio #(
        .NBTN(3),
        .DEBOUNCE_CYCLES(4),
        .BASE_ADR(32'h0000_2000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .adr(adr),
        .we(we),
        .wdata(wdata),
        .hit(hit),
        .rdata(rdata),
        .btn_level(btn_level),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        adr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        adr   = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int a = 32'h2000; a < 32'h2010; a++) begin
            rd(a, d);
            n_tests++;
            if (hit !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hit adr=%h got hit=%b want 1", a, hit);
            end
            n_tests++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata adr=%h got %h want 0", a, d);
            end
        end
        n_tests++;
        if (pending !== 1'b0 || btn_level !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outs got pending=%b level=%b want 0 000", pending, btn_level);
        end
        rd(32'h2010, d);
        n_tests++;
        if (hit !== 1'b0 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL miss_decode got hit=%b rdata=%h want 0 0", hit, d);
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] d;
        btn = 3'b010;
        repeat (5) tick();
        n_tests++;
        if (btn_level !== 3'b000) begin
            n_fail++;
            $display("FAIL press_early got level=%b want 000", btn_level);
        end
        tick();
        n_tests++;
        if (btn_level !== 3'b010 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL press_level got level=%b pending=%b want 010 1", btn_level, pending);
        end
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL press_events got %h want 2", d);
        end
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL press_count got %h want 1", d);
        end
        rd(32'h2000, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL press_status got %h want 2", d);
        end
        rd(32'h2007, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL low_bits_ignored got %h want 2", d);
        end
        rd(32'h2014, d);
        n_tests++;
        if (d !== 32'h0 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_masks got rdata=%h hit=%b want 0 0", d, hit);
        end
        btn = 3'b000;
        repeat (5) tick();
        n_tests++;
        if (btn_level !== 3'b010) begin
            n_fail++;
            $display("FAIL release_early got level=%b want 010", btn_level);
        end
        tick();
        n_tests++;
        if (btn_level !== 3'b000) begin
            n_fail++;
            $display("FAIL release_level got level=%b want 000", btn_level);
        end
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL release_events got %h want 2", d);
        end
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL release_count got %h want 1", d);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        do_reset();
        btn = 3'b001;
        repeat (3) tick();
        btn = 3'b000;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (btn_level !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch_level cycle=%0d got %b want 000", i, btn_level);
            end
        end
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_events got %h want 0", d);
        end
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL glitch_count got %h want 0", d);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        do_reset();
        btn = 3'b111;
        repeat (5) tick();
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL simul_count_early got %h want 0", d);
        end
        tick();
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h3) begin
            n_fail++;
            $display("FAIL simul_count got %h want 3", d);
        end
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h7 || btn_level !== 3'b111) begin
            n_fail++;
            $display("FAIL simul_events got ev=%h level=%b want 7 111", d, btn_level);
        end
        btn = 3'b000;
        repeat (6) tick();
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        wr(32'h2004, 32'h2);
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h5 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL w1c_bit1 got ev=%h pending=%b want 5 1", d, pending);
        end
        wr(32'h2000, 32'hFFFF_FFFF);
        wr(32'h2008, 32'hFFFF_FFFF);
        wr(32'h200C, 32'hFFFF_FFFF);
        wr(32'h3004, 32'hFFFF_FFFF);
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h5) begin
            n_fail++;
            $display("FAIL ignored_writes_events got %h want 5", d);
        end
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h3 || btn_level !== 3'b000) begin
            n_fail++;
            $display("FAIL ignored_writes_regs got count=%h level=%b want 3 000", d, btn_level);
        end
        wr(32'h2004, 32'h5);
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h0 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_all got ev=%h pending=%b want 0 0", d, pending);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        btn = 3'b001;
        repeat (5) tick();
        // store cycle whose ending edge is the one where level[0] rises
        wr(32'h2004, 32'h1);
        n_tests++;
        if (btn_level !== 3'b001 || pending !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins_level got level=%b pending=%b want 001 1", btn_level, pending);
        end
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL set_wins_events got %h want 1", d);
        end
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL set_wins_count got %h want 4", d);
        end
        btn = 3'b000;
        repeat (6) tick();
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        force dut.presses = 16'hFFFF;
        #1;
        release dut.presses;
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL wrap_preload got %h want ffff", d);
        end
        btn = 3'b010;
        repeat (6) tick();
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_count got %h want 0", d);
        end
        btn = 3'b000;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        btn = 3'b100;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (btn_level !== 3'b000 || pending !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outs got level=%b pending=%b want 000 0", btn_level, pending);
        end
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h0 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_events got %h hit=%b want 0 1", d, hit);
        end
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_count got %h want 0", d);
        end
        reset = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (btn_level !== 3'b000) begin
            n_fail++;
            $display("FAIL redebounce_early got level=%b want 000", btn_level);
        end
        tick();
        n_tests++;
        if (btn_level !== 3'b100) begin
            n_fail++;
            $display("FAIL redebounce_level got level=%b want 100", btn_level);
        end
        rd(32'h2004, d);
        n_tests++;
        if (d !== 32'h4) begin
            n_fail++;
            $display("FAIL redebounce_events got %h want 4", d);
        end
        rd(32'h2008, d);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL redebounce_count got %h want 1", d);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        btn     = '0;
        adr     = 32'h2000;
        we      = 1'b0;
        wdata   = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_w1c();
        test_set_wins();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_mmio.md
# button_mmio

Debounces the raw push-button inputs and exposes them to the processor as a small memory-mapped peripheral: live debounced levels, sticky press-event flags (write-1-to-clear) and a running press counter. It sits directly upstream of the processor's data-memory read path. It receives the raw `btn` pins from the board, and its `rdata` is muxed into the core's load data whenever `hit` is high.

## Interface

Parameters:
- `NBTN`, default 3: number of buttons.
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized input must differ from the current level before the level flips. Minimum is 2.
- `BASE_ADR`, default 32'h0000_2000: base of the 16-byte register window. Bits [3:0] are ignored.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `btn`, input, NBTN: raw, asynchronous, active-high button pins.
- `adr`, input, 32: processor data address (the core's `DataAdr`).
- `we`, input, 1: processor store strobe (the core's `MemWrite`).
- `wdata`, input, 32: processor store data (the core's `WriteData`).
- `hit`, output, 1: combinational. High when `adr[31:4] == BASE_ADR[31:4]`.
- `rdata`, output, 32: combinational read data. Equals 0 when `hit` is low.
- `btn_level`, output, NBTN: registered, debounced button levels.
- `pending`, output, 1: registered. OR of all event flags.

## Operation

Per-button datapath:
- Each button passes through a 2-flop synchronizer, `s1` then `s2`.
- Debounce counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide.
- Each clock edge, per button:
  - If `s2 == btn_level[i]`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `btn_level[i] <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never reaches `btn_level`, because the counter restarts on any return to the current level.
- Press event: the edge on which `btn_level[i]` goes 0→1 sets `events[i]`. Releases produce no event.

Register map (word offset is `adr[3:2]`, valid only when `hit` is high):
- Offset 0, STATUS, read-only: `rdata = {zeros, btn_level}`.
- Offset 1, EVENTS, read / write-1-to-clear. Read gives `{zeros, events}`. When `hit & we`, `events[i]` clears if `wdata[i]` is 1.
- Offset 2, COUNT, read-only: `rdata = {16'b0, presses}`.
  - `presses` is a 16-bit counter.
  - It increments by the number of buttons whose level rose on that edge (popcount, 0 to NBTN).
  - It wraps modulo 2^16.
- Offset 3: reserved. Reads return 0.
- Writes to offsets 0, 2 and 3 are ignored.

Boundary rules:
- A set and a W1C clear of the same event bit on the same edge: the set wins, and the bit stays 1.
- Several buttons rising on the same edge: all their event bits set, and `presses` adds the full popcount.
- A write with `hit` low has no effect.
- `adr[1:0]` is ignored.
- `pending` is registered from the next-state value of `events`, so it updates on the same edge as `events`.

Reset (synchronous, `reset` high at a clock edge):
- `s1`, `s2`, `cnt`, `btn_level`, `events`, `presses` and `pending` all go to 0.
- `hit` and `rdata` are combinational. While reset is held they follow `adr`, reading back the zeroed registers.
- A reset in the middle of debouncing discards the partial count. A button still held after reset goes through the full debounce again and then generates a fresh event.

## Timing

- Raw `btn` change sampled at edge k: `s2` shows it after edge k+1. `btn_level`, `events` and `presses` update at edge k+1+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=4, that is 5 edges after sampling.
- `rdata` is combinational from `adr` and the current registers. A load issued in the same cycle as an update sees the pre-edge value.
- A W1C clear takes effect at the edge that ends the store cycle. A read in the following cycle returns the cleared value.
- No stall or handshake. The block accepts a store every cycle.

## Test plan

Every scenario uses DEBOUNCE_CYCLES=4 and BASE_ADR=32'h0000_2000.

1. Reset value and address decode:
   - Assert `reset` for 2 edges, then read 0x2000, 0x2004, 0x2008 and 0x200C. Required: all return 0, `pending`=0, and `hit`=1 for every address in 0x2000–0x200F.
   - Read 0x2010. Required: `hit`=0 and `rdata`=0.
2. Clean press:
   - Raise `btn[1]` and hold. Required: `btn_level`=3'b010 exactly 5 edges after sampling, EVENTS=2 and COUNT=1 on that same edge, and `pending`=1.
   - Release. Required: `btn_level`=0 after 5 edges, with EVENTS and COUNT unchanged.
3. Glitch rejection: pulse `btn[0]` high for 3 cycles, then low. Required: `btn_level`, EVENTS and COUNT stay 0.
4. W1C:
   - With EVENTS=3'b111, store 32'h2 to 0x2004. Required: EVENTS=3'b101 and `pending`=1.
   - Store 32'h5 to 0x2004. Required: EVENTS=0 and `pending`=0.
   - Store to 0x2000. Required: no change to any register.
5. Simultaneous events:
   - Raise `btn` to 3'b111 in a single cycle. Required: COUNT increments by 3 on one edge.
   - Issue a W1C of bit 0 on the exact edge where `btn[0]`'s level rises. Required: `events[0]` stays 1.
   - Preload `presses`=16'hFFFF, then one press. Required: COUNT=0.
6. Reset mid-debounce:
   - Hold `btn[2]` high and assert `reset` after 3 synchronized cycles. Required: all registers return to 0.
   - Deassert `reset` with `btn[2]` still high. Required: `btn_level[2]` rises 5 edges later, with EVENTS=3'b100 and COUNT=1.
